// File: rtl/dmem_responder.sv
// Multi-cycle data memory: one read/write per transaction on 16-bit words; optional DMEM_ALIGN_CHECK_EN flags odd addresses.
// Latency: request-to-done is LATENCY+1 cycles; one transaction per LATENCY+2 cycles (misaligned: done in cycle 1).
// Backpressure: combinational stall holds the requester in the accept cycle and through BUSY; it is released in the DONE cycle.
module dmem_responder #(
    parameter int LATENCY   = 4,
    parameter int ADDR_BITS = 8
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        enable,
    input  logic        wr,
    input  logic [15:0] addr,
    input  logic [15:0] data_in,
    output logic [15:0] data_out,
    output logic        stall,
    output logic        done,
    output logic        err
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        BUSY = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t                 state;
    state_t                 nextState;
    logic [3:0]             count;
    logic                   pendWr;
    logic [ADDR_BITS-1:0]   pendIdx;
    logic [15:0]            pendData;
    logic                   accept;
    logic                   lastBusy;
    logic                   misaligned;
    logic [ADDR_BITS-1:0]   reqIdx;
    logic                   unusedAddrBits;

    logic [15:0] mem [2**ADDR_BITS];

    // Upper address bits alias onto the array; addr[0] only matters to the alignment check.
    assign reqIdx         = addr[ADDR_BITS:1];
    assign unusedAddrBits = ^addr;

`ifdef DMEM_ALIGN_CHECK_EN
    logic errFlag;

    assign misaligned = addr[0];
    assign err        = done & errFlag;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            errFlag <= 1'b0;
        end else if (accept) begin
            errFlag <= misaligned;
        end
    end
`else
    assign misaligned = 1'b0;
    assign err        = 1'b0;
`endif

    always_comb begin
        nextState = state;
        stall     = 1'b0;
        done      = 1'b0;
        accept    = 1'b0;
        lastBusy  = 1'b0;
        case (state)
            IDLE: begin
                stall = enable;
                if (enable) begin
                    accept    = 1'b1;
                    nextState = misaligned ? DONE : BUSY;
                end
            end
            BUSY: begin
                stall = 1'b1;
                if (count == 4'd1) begin
                    lastBusy  = 1'b1;
                    nextState = DONE;
                end
            end
            // enable still carries the finished request here, so it is ignored.
            DONE: begin
                done      = 1'b1;
                nextState = IDLE;
            end
            default: nextState = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state    <= IDLE;
            count    <= 4'd0;
            pendWr   <= 1'b0;
            pendIdx  <= '0;
            pendData <= 16'h0000;
            data_out <= 16'h0000;
        end else begin
            state <= nextState;
            if (accept) begin
                count    <= misaligned ? 4'd0 : 4'(LATENCY);
                pendWr   <= wr;
                pendIdx  <= reqIdx;
                pendData <= data_in;
            end else if (state == BUSY) begin
                count <= count - 4'd1;
            end
            if (lastBusy && !pendWr) begin
                data_out <= mem[pendIdx];
            end
        end
    end

    // Storage has no reset; an aborted transaction never reaches lastBusy, so its write is dropped.
    always_ff @(posedge clk) begin
        if (lastBusy && pendWr && !rst) begin
            mem[pendIdx] <= pendData;
        end
    end

endmodule

// File: tb/tb_dmem_responder.sv
// Directed plus randomized transactions against an associative-array memory model of dmem_responder.
module tb_dmem_responder;

    localparam int LAT = 4;
    localparam int AB  = 8;
`ifdef DMEM_ALIGN_CHECK_EN
    localparam bit ALIGN = 1'b1;
`else
    localparam bit ALIGN = 1'b0;
`endif

    logic        clk = 1'b0;
    logic        rst;
    logic        enable;
    logic        wr;
    logic [15:0] addr;
    logic [15:0] data_in;
    logic [15:0] data_out;
    logic        stall;
    logic        done;
    logic        err;

    int checks = 0;
    int passed = 0;

    logic [15:0] model [int];
    logic [15:0] expOut;
    int          pool [8];

    dmem_responder #(.LATENCY(LAT), .ADDR_BITS(AB)) dut (
        .clk      (clk),
        .rst      (rst),
        .enable   (enable),
        .wr       (wr),
        .addr     (addr),
        .data_in  (data_in),
        .data_out (data_out),
        .stall    (stall),
        .done     (done),
        .err      (err)
    );

    initial forever #5 clk = ~clk;

    initial begin
        #400000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    task automatic check(input string tag, input logic [15:0] obs, input logic [15:0] exp);
        checks++;
        assert (obs === exp) passed++;
        else $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    endtask

    function automatic int wordOf(input logic [15:0] a);
        return (int'(a) / 2) % (1 << AB);
    endfunction

    // Called just after a falling edge; returns at a falling edge (+1 unit when enable is dropped).
    task automatic txn(input bit w, input logic [15:0] a, input logic [15:0] d, input bit keepEn);
        bit mis;
        int busy;
        mis  = ALIGN && a[0];
        busy = mis ? 0 : LAT;
        enable  = 1'b1;
        wr      = w;
        addr    = a;
        data_in = d;
        #1;
        check("stall_c0", stall, 16'(1));
        check("done_c0", done, 16'(0));
        for (int i = 1; i <= busy; i++) begin
            @(negedge clk); #1;
            check("stall_busy", stall, 16'(1));
            check("done_busy", done, 16'(0));
        end
        @(negedge clk); #1;
        if (!mis) begin
            if (w) model[wordOf(a)] = d;
            else   expOut = model[wordOf(a)];
        end
        check("done_pulse", done, 16'(1));
        check("stall_done", stall, 16'(0));
        check("err_done", err, 16'(mis));
        check("data_done", data_out, expOut);
        @(negedge clk);
        if (!keepEn) begin
            enable = 1'b0;
            #1;
            check("done_after", done, 16'(0));
            check("stall_idle", stall, 16'(0));
            check("data_held", data_out, expOut);
        end
    endtask

    initial begin
        logic [15:0] a;
        bit          w;
        bit          keep;
        int          k;

        rst = 1'b1; enable = 1'b0; wr = 1'b0; addr = 16'h0; data_in = 16'h0;
        expOut = 16'h0000;
        @(negedge clk); #1;
        check("rst_data_out", data_out, 16'h0000);
        check("rst_done", done, 16'(0));
        check("rst_err", err, 16'(0));
        check("rst_stall", stall, 16'(0));
        enable = 1'b1; #1;
        check("rst_stall_follows_en", stall, 16'(1));
        enable = 1'b0;
        @(negedge clk); rst = 1'b0;
        @(negedge clk);

        txn(1'b1, 16'h0010, 16'hBEEF, 1'b0);
        txn(1'b0, 16'h0010, 16'h0000, 1'b0);
        check("read_beef", data_out, 16'hBEEF);

        txn(1'b1, 16'h0000, 16'h1111, 1'b0);
        txn(1'b0, 16'h0200, 16'h0000, 1'b0);
        check("alias_word0", data_out, 16'h1111);
        txn(1'b1, 16'h01FE, 16'h2222, 1'b0);
        txn(1'b0, 16'h03FE, 16'h0000, 1'b0);
        check("alias_word255", data_out, 16'h2222);

        // Reset in cycle 2 of a write aborts it.
        txn(1'b1, 16'h0020, 16'h5555, 1'b0);
        enable = 1'b1; wr = 1'b1; addr = 16'h0020; data_in = 16'h1234;
        @(negedge clk);
        @(negedge clk);
        rst = 1'b1; #1;
        expOut = 16'h0000;
        check("abort_done", done, 16'(0));
        check("abort_data_out", data_out, 16'h0000);
        enable = 1'b0; #1;
        check("abort_idle_stall", stall, 16'(0));
        @(negedge clk); #1;
        check("abort_no_done", done, 16'(0));
        rst = 1'b0;
        @(negedge clk);
        txn(1'b0, 16'h0020, 16'h0000, 1'b0);
        check("abort_kept_old", data_out, 16'h5555);

        // enable held through DONE: each transaction yields a single done.
        txn(1'b1, 16'h0040, 16'hAAAA, 1'b0);
        txn(1'b0, 16'h0040, 16'h0000, 1'b1);
        check("b2b_old", data_out, 16'hAAAA);
        txn(1'b1, 16'h0040, 16'h4444, 1'b1);
        txn(1'b0, 16'h0040, 16'h0000, 1'b0);
        check("b2b_new", data_out, 16'h4444);

        txn(1'b1, 16'h0011, 16'h9999, 1'b0);
        txn(1'b0, 16'h0010, 16'h0000, 1'b0);
        check("align_word8", data_out, ALIGN ? 16'hBEEF : 16'h9999);

        // Reset during DONE kills the pulse at once; the write already landed.
        enable = 1'b1; wr = 1'b1; addr = 16'h0080; data_in = 16'hCAFE;
        for (int i = 0; i <= LAT; i++) @(negedge clk);
        #1;
        check("rstdone_pre", done, 16'(1));
        rst = 1'b1; #1;
        check("rstdone_cut", done, 16'(0));
        check("rstdone_data_out", data_out, 16'h0000);
        model[wordOf(16'h0080)] = 16'hCAFE;
        expOut = 16'h0000;
        enable = 1'b0;
        @(negedge clk); rst = 1'b0;
        @(negedge clk);
        txn(1'b0, 16'h0080, 16'h0000, 1'b0);
        check("rstdone_written", data_out, 16'hCAFE);

        for (int i = 0; i < 8; i++) begin
            pool[i] = $urandom_range(0, (1 << AB) - 1);
            txn(1'b1, 16'(pool[i] * 2), 16'($urandom), 1'b0);
        end
        for (int i = 0; i < 40; i++) begin
            k    = $urandom_range(0, 7);
            a    = 16'(($urandom_range(0, 127) << 9) | (pool[k] << 1) | $urandom_range(0, 1));
            w    = 1'($urandom_range(0, 1));
            keep = ($urandom_range(0, 3) == 0);
            txn(w, a, 16'($urandom), keep);
        end
        enable = 1'b0;
        @(negedge clk); #1;
        check("final_idle_done", done, 16'(0));

        $display("%0d/%0d checks passed", passed, checks);
        $finish;
    end

endmodule

// File: doc/dmem_responder.md
# dmem_responder

Multi-cycle data-memory responder sitting on the far side of the pipeline's memory-stage request interface. It replaces the single-cycle data memory: it accepts one read or write per transaction, holds the pipeline with a combinational `stall` for a fixed `LATENCY` cycles, then completes the access and pulses `done`. Storage is an internal word-addressed array of 16-bit words.

## Interface
- `LATENCY`, default 4: BUSY cycles per transaction; legal range 1..15.
- `ADDR_BITS`, default 8: word-index width; array depth is 2^ADDR_BITS words.

- `clk`  in  1  single clock; all state updates on rising edge.
- `rst`  in  1  reset, asynchronous, active-high.
- `enable`  in  1  request valid; requester holds it and all request fields stable while `stall`=1.
- `wr`  in  1  1 = write, 0 = read; sampled with `enable`.
- `addr`  in  16  byte address; word index = `addr[ADDR_BITS:1]`.
- `data_in`  in  16  write data.
- `data_out`  out  16  read data; valid in the `done` cycle of a read, then held.
- `stall`  out  1  combinational; holds the requester.
- `done`  out  1  one-cycle completion pulse.
- `err`  out  1  one-cycle unaligned-access flag, coincident with `done` (only with `DMEM_ALIGN_CHECK_EN`).

## Operation
- FSM states: IDLE, BUSY, DONE.
- IDLE: if `enable`=1, latch `wr`, word index and `data_in`; load the down-counter with `LATENCY`; go to BUSY. Otherwise stay.
- BUSY: decrement the counter each cycle. At the edge where counter = 1, perform the access and go to DONE.
  - Write: array[index] <= latched data.
  - Read: `data_out` <= array[index].
- DONE: `done`=1 for exactly one cycle. `enable` is ignored, because it still carries the completed request. Unconditionally return to IDLE.
- `stall` = (IDLE & `enable`) | BUSY. It is 0 in DONE, so the requester advances at the end of the DONE cycle.
- Address aliasing: bits above `ADDR_BITS` and `addr[0]` are ignored by indexing. Out-of-range addresses wrap modulo 2^ADDR_BITS words.
- `data_out` changes only on read completion. Writes leave it unchanged.
- Array contents are not affected by reset.

## Timing
- Cycle 0: request presented, `stall`=1, request captured at the end of the cycle.
- Cycles 1..LATENCY: BUSY, `stall`=1.
- Cycle LATENCY+1: `done`=1, `stall`=0.
- The next request can be presented no earlier than cycle LATENCY+2.
- Total request-to-done latency is LATENCY+1 cycles. Throughput is one transaction per LATENCY+2 cycles.
- A write is visible to any request accepted after its `done` cycle.
- Reset values: state IDLE, counter 0, `data_out`=0x0000, `done`=0, `err`=0.
  - `stall` follows `enable` while in IDLE.
- Reset mid-BUSY aborts the transaction:
  - A pending write is discarded and the array is unchanged.
  - No `done` is issued.
- Reset asserted during DONE suppresses the remainder of the pulse immediately.

## Configuration
- `DMEM_ALIGN_CHECK_EN` defined:
  - An IDLE request with `addr[0]`=1 does not enter BUSY; it goes directly to DONE.
  - The array and `data_out` are unchanged.
  - `err`=1 together with `done`.
  - `stall`=1 in cycle 0 only.
- Not defined:
  - `addr[0]` is ignored.
  - `err` is tied to 0.
  - Every request takes the full LATENCY path.

## Test plan
- Defaults: LATENCY=4, ADDR_BITS=8.
- Write 0xBEEF to 0x0010, then read 0x0010 -> each transaction has `stall` high cycles 0–4 and `done` in cycle 5; the read returns `data_out`=0xBEEF, held after `done`.
- Write 0x1111 to 0x0000, then read 0x0200 -> aliases to word 0, `data_out`=0x1111. Then write 0x2222 to 0x01FE and read 0x03FE -> 0x2222.
- Write 0x5555 to 0x0020. Start a write of 0x1234 to 0x0020 and assert `rst` in cycle 2 -> no `done`, state IDLE, `data_out`=0. A subsequent read of 0x0020 -> 0x5555.
- Hold `enable`=1 through DONE with the same read -> exactly one `done` per transaction. Back-to-back read/write/read to 0x0040 across three transactions returns the old value, then the new one.
- Rebuild with LATENCY=1 -> `stall` high cycles 0–1, `done` in cycle 2. A read following a write returns the written value.
- With `DMEM_ALIGN_CHECK_EN`: write to 0x0011 -> `done`=`err`=1 in cycle 1 and word 8 unchanged. Without the macro: the same write takes 5 stall cycles, stores to word 8, and `err` stays 0.
